decode_queued: RTL and testbench
================================

// Module: decode_queued
// PURPOSE
//  Decode stage with a DEPTH-entry fetch/decode instruction queue replacing the single IF/ID register.
//  Valid/ready handshakes on both sides decouple fetch from decode stalls.
//  Decodes the queue head into control, register-file reads, immediate and an illegal-opcode flag.
//  Sits between fetch and the ID/EX register; the WB write port enters here.
// PARAMETERS
//  XLEN       32  datapath width
//  DEPTH      4   queue entries; power of two, >=2
//  BYPASS_EN  1   1: same-cycle WB->read write-through on RD1D/RD2D; 0: plain regfile read
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  ValidF       in   1       fetch beat valid
//  ReadyF       out  1       queue accepts a beat this cycle
//  InstrF       in   32      fetched instruction
//  PCF          in   XLEN    fetch PC
//  PCPlus4F     in   XLEN    fetch PC+4
//  StallD       in   1       hazard unit: hold the head entry
//  FlushD       in   1       hazard unit: discard all queued entries
//  RegWriteW    in   1       WB write enable
//  RdW          in   5       WB destination
//  ResultW      in   XLEN    WB data
//  ValidD       out  1       head entry present and decoded
//  IllegalD     out  1       head opcode unsupported
//  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  out 1 each  control
//  ResultSrcD   out  2       result select
//  ALUControlD  out  alu_op_e  ALU operation
//  RD1D, RD2D   out  XLEN    register operands
//  Rs1D, Rs2D, RdD  out 5    register indices
//  ExtImmD, PCD, PCPlus4D  out XLEN  immediate, PC, PC+4
//  CountD       out  $clog2(DEPTH+1)  entries held
// BEHAVIOUR
//  - Reset: count=0, head/tail pointers=0 -> ValidD=0, ReadyF=1, CountD=0, all other outputs 0.
//    The register array is not reset.
//  - push = ValidF & ReadyF & ~FlushD; pop = ValidD & ~StallD.
//  - ReadyF = (count<DEPTH) | pop. Full with a simultaneous pop accepts the push.
//  - Push writes {InstrF,PCF,PCPlus4F} at tail and advances tail mod DEPTH.
//  - Pop advances head mod DEPTH. Push+pop together leave count unchanged.
//  - Latency: an entry pushed in cycle N is earliest at head (ValidD=1) in cycle N+1.
//  - FlushD: next cycle count=0 and head=tail; the same-cycle fetch beat is dropped.
//    FlushD overrides StallD.
//  - StallD with ValidD=1: head and every output held stable; pushes continue while not full.
//  - Empty (ValidD=0): all control outputs 0 (NOP); datapath outputs 0; IllegalD=0.
//  - Decode is combinational from the head entry.
//    Supported opcodes: LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011,
//    BRANCH 1100011, JAL 1101111.
//  - Any other opcode with ValidD=1: IllegalD=1 and controls forced to NOP.
//    The entry still pops normally.
//  - Register file: 32xXLEN, written at posedge when RegWriteW & RdW!=0; x0 always reads 0.
//  - BYPASS_EN=1: if RegWriteW & RdW!=0 & RdW==Rs1D then RD1D=ResultW; same rule for Rs2D/RD2D.
//  - Rs1D/Rs2D/RdD are the raw instruction fields of the head entry. They are 0 when ValidD=0.
// STRUCTURE
//  - riscv_pkg gains:
//    - OPC_* opcode localparams;
//    - fd_entry_t struct {instr, pc, pc_plus4};
//    - fd_entry_t is reused with the existing alu_op_e and imm_src_e.
//  - Sub-module instr_queue: parametrised FIFO of fd_entry_t with push/pop/flush/count.
//  - Existing controller and imm_extend are instantiated for field decode. Regfile is inline with bypass.
// TESTING
//  - Reset, idle: ValidF=0 -> ValidD=0, ReadyF=1, CountD=0, RegWriteD=0.
//  - Single beat: push addi x1,x0,5 (0x00500093) at PC 0x0 -> next cycle:
//    ValidD=1, RegWriteD=1, ALUSrcD=1, ExtImmD=5, RdD=1.
//  - Fill: StallD=1, push 5 beats at DEPTH=4 -> CountD=4, ReadyF=0 on the 5th beat.
//    Then StallD=0 with ValidF=1 -> push+pop same cycle, CountD stays 4.
//  - Flush: 3 entries held, FlushD=1 with ValidF=1 -> next cycle CountD=0, ValidD=0; the beat is dropped.
//  - Bypass: RegWriteW=1, RdW=1, ResultW=0xDEADBEEF, head is add x2,x1,x1 ->
//    RD1D=RD2D=0xDEADBEEF same cycle.
//    With RdW=0 -> RD1D=0.
//  - Illegal: push 0x00000037 (LUI) -> ValidD=1, IllegalD=1, RegWriteD=0; pops on the next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared types for the RV32 pipeline front end.
//   OPC_*      : major opcodes understood by the decoder
//   alu_op_e   : ALU operation select driven into EX
//   imm_src_e  : immediate format select for imm_extend
//   fd_entry_t : one fetch/decode queue entry {instr, pc, pc_plus4}
// ----------------------------------------------------------------------------
package riscv_pkg;

  // Width of the PC fields held in fd_entry_t.
  localparam int unsigned Xlen = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluXor = 3'b100,
    AluSlt = 3'b101,
    AluSll = 3'b110,
    AluSrl = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ImmI = 2'b00,
    ImmS = 2'b01,
    ImmB = 2'b10,
    ImmJ = 2'b11
  } imm_src_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [Xlen-1:0] pc;
    logic [Xlen-1:0] pc_plus4;
  } fd_entry_t;

endpackage

// File: rtl/controller.sv
// ----------------------------------------------------------------------------
// controller
// Main and ALU decoder for the supported RV32I subset.
//   op_i, funct3_i, funct7b5_i : instruction fields
//   reg_write_o, mem_write_o, jump_o, branch_o, alu_src_o, result_src_o
//                              : control bundle for later stages
//   imm_src_o                  : immediate format for imm_extend
//   alu_control_o              : ALU operation
//   illegal_o                  : opcode not supported (all controls stay 0)
// ----------------------------------------------------------------------------
module controller
  import riscv_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       jump_o,
  output logic       branch_o,
  output logic       alu_src_o,
  output logic [1:0] result_src_o,
  output imm_src_e   imm_src_o,
  output alu_op_e    alu_control_o,
  output logic       illegal_o
);

  logic arith;

  always_comb begin
    reg_write_o   = 1'b0;
    mem_write_o   = 1'b0;
    jump_o        = 1'b0;
    branch_o      = 1'b0;
    alu_src_o     = 1'b0;
    result_src_o  = 2'b00;
    imm_src_o     = ImmI;
    alu_control_o = AluAdd;
    illegal_o     = 1'b0;
    arith         = 1'b0;

    case (op_i)
      OPC_LOAD: begin
        reg_write_o  = 1'b1;
        alu_src_o    = 1'b1;
        result_src_o = 2'b01;
      end
      OPC_STORE: begin
        mem_write_o = 1'b1;
        alu_src_o   = 1'b1;
        imm_src_o   = ImmS;
      end
      OPC_OP: begin
        reg_write_o = 1'b1;
        arith       = 1'b1;
      end
      OPC_OP_IMM: begin
        reg_write_o = 1'b1;
        alu_src_o   = 1'b1;
        arith       = 1'b1;
      end
      OPC_BRANCH: begin
        branch_o      = 1'b1;
        imm_src_o     = ImmB;
        alu_control_o = AluSub;
      end
      OPC_JAL: begin
        reg_write_o  = 1'b1;
        jump_o       = 1'b1;
        result_src_o = 2'b10;
        imm_src_o    = ImmJ;
      end
      default: illegal_o = 1'b1;
    endcase

    if (arith) begin
      case (funct3_i)
        // funct7[5] selects SUB only for register-register ops; on OP-IMM it is immediate data.
        3'b000:  alu_control_o = (op_i == OPC_OP && funct7b5_i) ? AluSub : AluAdd;
        3'b001:  alu_control_o = AluSll;
        3'b010:  alu_control_o = AluSlt;
        3'b100:  alu_control_o = AluXor;
        3'b101:  alu_control_o = AluSrl;
        3'b110:  alu_control_o = AluOr;
        3'b111:  alu_control_o = AluAnd;
        default: alu_control_o = AluAdd;
      endcase
    end
  end

endmodule

// File: rtl/imm_extend.sv
// ----------------------------------------------------------------------------
// imm_extend
// Builds the sign-extended immediate for I/S/B/J formats.
//   instr_i   : instruction bits [31:7]
//   imm_src_i : immediate format
//   imm_ext_o : sign-extended immediate, Width bits
// ----------------------------------------------------------------------------
module imm_extend
  import riscv_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [31:7]      instr_i,
  input  imm_src_e         imm_src_i,
  output logic [Width-1:0] imm_ext_o
);

  logic [31:0] imm32;

  always_comb begin
    unique case (imm_src_i)
      ImmI: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      ImmS: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      ImmB: imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      ImmJ: imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_ext_o = Width'($signed(imm32));

endmodule

// File: rtl/instr_queue.sv
// ----------------------------------------------------------------------------
// instr_queue
// Circular FIFO of fd_entry_t between fetch and decode.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : write entry_i at tail
//   pop_i        : retire the head entry
//   flush_i      : drop every entry (wins over push/pop)
//   entry_i      : incoming entry
//   head_o       : entry at head (meaningless when empty_o)
//   count_o      : entries held
//   full_o       : count_o == Depth
//   empty_o      : count_o == 0
// ----------------------------------------------------------------------------
module instr_queue
  import riscv_pkg::*;
#(
  parameter  int unsigned Depth = 4,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  fd_entry_t       entry_i,
  output fd_entry_t       head_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  fd_entry_t       mem_q [Depth];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  // Depth is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + PtrW'(1);
      if (pop_i)  head_d = head_q + PtrW'(1);
      if (push_i && !pop_i)      count_d = count_q + CntW'(1);
      else if (!push_i && pop_i) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; empty_o masks its contents downstream.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[tail_q] <= entry_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/decode_queued.sv
// ----------------------------------------------------------------------------
// decode_queued
// Decode stage fed by a DEPTH-entry instruction queue instead of an IF/ID register.
//   clk, rst                  : clock, synchronous active-high reset
//   ValidF/ReadyF             : fetch handshake; InstrF, PCF, PCPlus4F fetch beat
//   StallD, FlushD            : hazard unit hold / discard-all (FlushD wins)
//   RegWriteW, RdW, ResultW   : writeback port into the register file
//   ValidD, IllegalD          : head present / head opcode unsupported
//   RegWriteD..ALUControlD    : control bundle (NOP when empty or illegal)
//   RD1D, RD2D                : operands, optional WB write-through
//   Rs1D, Rs2D, RdD           : raw register fields of the head
//   ExtImmD, PCD, PCPlus4D    : immediate and PCs of the head
//   CountD                    : entries held
// ----------------------------------------------------------------------------
module decode_queued
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 4,
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ValidF,
  output logic                       ReadyF,
  input  logic [31:0]                InstrF,
  input  logic [XLEN-1:0]            PCF,
  input  logic [XLEN-1:0]            PCPlus4F,
  input  logic                       StallD,
  input  logic                       FlushD,
  input  logic                       RegWriteW,
  input  logic [4:0]                 RdW,
  input  logic [XLEN-1:0]            ResultW,
  output logic                       ValidD,
  output logic                       IllegalD,
  output logic                       RegWriteD,
  output logic                       MemWriteD,
  output logic                       JumpD,
  output logic                       BranchD,
  output logic                       ALUSrcD,
  output logic [1:0]                 ResultSrcD,
  output alu_op_e                    ALUControlD,
  output logic [XLEN-1:0]            RD1D,
  output logic [XLEN-1:0]            RD2D,
  output logic [4:0]                 Rs1D,
  output logic [4:0]                 Rs2D,
  output logic [4:0]                 RdD,
  output logic [XLEN-1:0]            ExtImmD,
  output logic [XLEN-1:0]            PCD,
  output logic [XLEN-1:0]            PCPlus4D,
  output logic [$clog2(DEPTH+1)-1:0] CountD
);

  logic      push, pop, q_full, q_empty;
  fd_entry_t entry_in, head;

  assign ValidD = ~q_empty;
  assign pop    = ValidD & ~StallD;
  // A full queue still accepts when the head leaves this cycle.
  assign ReadyF = ~q_full | pop;
  assign push   = ValidF & ReadyF & ~FlushD;

  assign entry_in = '{instr: InstrF, pc: Xlen'(PCF), pc_plus4: Xlen'(PCPlus4F)};

  instr_queue #(
    .Depth (DEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (FlushD),
    .entry_i (entry_in),
    .head_o  (head),
    .count_o (CountD),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  logic       c_reg_write, c_mem_write, c_jump, c_branch, c_alu_src, c_illegal;
  logic [1:0] c_result_src;
  imm_src_e   c_imm_src;
  alu_op_e    c_alu_control;

  controller u_controller (
    .op_i          (head.instr[6:0]),
    .funct3_i      (head.instr[14:12]),
    .funct7b5_i    (head.instr[30]),
    .reg_write_o   (c_reg_write),
    .mem_write_o   (c_mem_write),
    .jump_o        (c_jump),
    .branch_o      (c_branch),
    .alu_src_o     (c_alu_src),
    .result_src_o  (c_result_src),
    .imm_src_o     (c_imm_src),
    .alu_control_o (c_alu_control),
    .illegal_o     (c_illegal)
  );

  logic [XLEN-1:0] imm_ext;

  imm_extend #(
    .Width (XLEN)
  ) u_imm_extend (
    .instr_i   (head.instr[31:7]),
    .imm_src_i (c_imm_src),
    .imm_ext_o (imm_ext)
  );

  // Register file; x0 is never written and always reads zero.
  logic [XLEN-1:0] rf_q [32];
  logic            wb_hit;

  assign wb_hit = RegWriteW && (RdW != 5'd0);

  always_ff @(posedge clk) begin
    if (wb_hit) rf_q[RdW] <= ResultW;
  end

  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] rd1, rd2;

  assign rs1 = head.instr[19:15];
  assign rs2 = head.instr[24:20];

  always_comb begin
    rd1 = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    rd2 = (rs2 == 5'd0) ? '0 : rf_q[rs2];
    // Write-through lets a same-cycle WB value reach decode without a stall.
    if (BYPASS_EN && wb_hit && (RdW == rs1)) rd1 = ResultW;
    if (BYPASS_EN && wb_hit && (RdW == rs2)) rd2 = ResultW;
  end

  always_comb begin
    IllegalD    = 1'b0;
    RegWriteD   = 1'b0;
    MemWriteD   = 1'b0;
    JumpD       = 1'b0;
    BranchD     = 1'b0;
    ALUSrcD     = 1'b0;
    ResultSrcD  = 2'b00;
    ALUControlD = AluAdd;
    RD1D        = '0;
    RD2D        = '0;
    Rs1D        = '0;
    Rs2D        = '0;
    RdD         = '0;
    ExtImmD     = '0;
    PCD         = '0;
    PCPlus4D    = '0;
    if (ValidD) begin
      IllegalD = c_illegal;
      if (!c_illegal) begin
        RegWriteD   = c_reg_write;
        MemWriteD   = c_mem_write;
        JumpD       = c_jump;
        BranchD     = c_branch;
        ALUSrcD     = c_alu_src;
        ResultSrcD  = c_result_src;
        ALUControlD = c_alu_control;
      end
      RD1D     = rd1;
      RD2D     = rd2;
      Rs1D     = rs1;
      Rs2D     = rs2;
      RdD      = head.instr[11:7];
      ExtImmD  = imm_ext;
      PCD      = XLEN'(head.pc);
      PCPlus4D = XLEN'(head.pc_plus4);
    end
  end

endmodule

// File: tb/tb_decode_queued.sv
module tb_decode_queued;
  import riscv_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic            clk, rst;
  logic            ValidF, ReadyF, StallD, FlushD, RegWriteW;
  logic [31:0]     InstrF;
  logic [XLEN-1:0] PCF, PCPlus4F, ResultW;
  logic [4:0]      RdW;
  logic            ValidD, IllegalD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]      ResultSrcD;
  alu_op_e         ALUControlD;
  logic [XLEN-1:0] RD1D, RD2D, ExtImmD, PCD, PCPlus4D;
  logic [4:0]      Rs1D, Rs2D, RdD;
  logic [$clog2(DEPTH+1)-1:0] CountD;

  decode_queued #(.XLEN(XLEN), .DEPTH(DEPTH), .BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .ValidF(ValidF), .ReadyF(ReadyF), .InstrF(InstrF), .PCF(PCF),
    .PCPlus4F(PCPlus4F), .StallD(StallD), .FlushD(FlushD), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .ValidD(ValidD), .IllegalD(IllegalD), .RegWriteD(RegWriteD),
    .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ExtImmD(ExtImmD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .CountD(CountD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    int          tag;
  } sb_t;

  typedef struct packed {
    logic        ill, rw, mw, jmp, br, asrc;
    logic [1:0]  rsrc;
    logic [2:0]  alu;
    logic [31:0] imm;
  } dec_t;

  sb_t         sb[$];
  logic [31:0] rf_m [32];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] pc_ctr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sign-extend the low 'bits' of v using arithmetic only.
  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] s, m;
    s = 32'd1 << (bits - 1);
    m = (s << 1) - 32'd1;
    return ((v & m) ^ s) - s;
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
    case (f3)
      3'd0:    return sub ? AluSub : AluAdd;
      3'd1:    return AluSll;
      3'd2:    return AluSlt;
      3'd4:    return AluXor;
      3'd5:    return AluSrl;
      3'd6:    return AluOr;
      3'd7:    return AluAnd;
      default: return AluAdd;
    endcase
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t        d;
    logic [31:0] immi, imms, immb, immj;
    immi = sext(ins >> 20, 12);
    imms = sext(((ins >> 25) << 5) | ((ins >> 7) & 32'h1f), 12);
    immb = sext((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
                (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1), 13);
    immj = sext((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12) |
                (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1), 21);
    d = '0;
    d.imm = immi;
    case (ins & 32'h7f)
      32'h03: begin d.rw = 1; d.asrc = 1; d.rsrc = 2'd1; end
      32'h23: begin d.mw = 1; d.asrc = 1; d.imm = imms; end
      32'h33: begin d.rw = 1; d.alu = alu_of(ins[14:12], ins[30]); end
      32'h13: begin d.rw = 1; d.asrc = 1; d.alu = alu_of(ins[14:12], 1'b0); end
      32'h63: begin d.br = 1; d.alu = AluSub; d.imm = immb; end
      32'h6f: begin d.rw = 1; d.jmp = 1; d.rsrc = 2'd2; d.imm = immj; end
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] rd_exp(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (RegWriteW && RdW != 0 && RdW == idx) return ResultW;
    return rf_m[idx];
  endfunction

  // Monitor: compares DUT outputs against the scoreboard head every cycle.
  always @(negedge clk) begin
    int   n;
    sb_t  e;
    dec_t d;
    if (!rst) begin
      n = 0;
      foreach (sb[i]) if (sb[i].tag < cyc) n++;
      chk("ValidD", ValidD, n > 0);
      chk("CountD", CountD, n);
      chk("ReadyF", ReadyF, (n < DEPTH) || (n > 0 && !StallD));
      if (n > 0) begin
        e = sb[0];
        d = ref_decode(e.instr);
        chk("IllegalD", IllegalD, d.ill);
        chk("RegWriteD", RegWriteD, d.rw);
        chk("MemWriteD", MemWriteD, d.mw);
        chk("JumpD", JumpD, d.jmp);
        chk("BranchD", BranchD, d.br);
        chk("ALUSrcD", ALUSrcD, d.asrc);
        chk("ResultSrcD", ResultSrcD, d.rsrc);
        chk("ALUControlD", ALUControlD, d.alu);
        chk("ExtImmD", ExtImmD, d.imm);
        chk("PCD", PCD, e.pc);
        chk("PCPlus4D", PCPlus4D, e.pc + 4);
        chk("Rs1D", Rs1D, (e.instr >> 15) & 31);
        chk("Rs2D", Rs2D, (e.instr >> 20) & 31);
        chk("RdD", RdD, (e.instr >> 7) & 31);
        chk("RD1D", RD1D, rd_exp(e.instr[19:15]));
        chk("RD2D", RD2D, rd_exp(e.instr[24:20]));
      end else begin
        chk("empty ctrl", {IllegalD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD,
                           ALUControlD}, 32'h0);
        chk("empty data", RD1D | RD2D | ExtImmD | PCD | PCPlus4D, 32'h0);
        chk("empty regs", {Rs1D, Rs2D, RdD}, 32'h0);
      end
      if (RegWriteW && RdW != 0) rf_m[RdW] = ResultW;
      if (FlushD) sb.delete();
      else if (n > 0 && !StallD) void'(sb.pop_front());
    end
  end

  // Driver: one call per cycle; pushes the expected entry when the beat is accepted.
  task automatic drive(input logic v, input logic [31:0] ins, input logic st, input logic fl,
                       input logic we, input logic [4:0] rd, input logic [31:0] res);
    int  n;
    sb_t e;
    @(posedge clk);
    #1;
    ValidF    = v;
    InstrF    = ins;
    PCF       = pc_ctr;
    PCPlus4F  = pc_ctr + 4;
    StallD    = st;
    FlushD    = fl;
    RegWriteW = we;
    RdW       = rd;
    ResultW   = res;
    n = sb.size();
    if (v && !fl && (n < DEPTH || (n > 0 && !st))) begin
      e.instr = ins;
      e.pc    = pc_ctr;
      e.tag   = cyc;
      sb.push_back(e);
    end
    pc_ctr = pc_ctr + 4;
  endtask

  task automatic idle(input logic st);
    drive(1'b0, 32'h0, st, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9];
    logic [31:0] r;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h37, 7'h17, 7'h7f};
    r = $urandom;
    return {r[31:7], ops[$urandom_range(0, 8)]};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
    rst = 1'b1;
    ValidF = 0; InstrF = 0; PCF = 0; PCPlus4F = 0; StallD = 0; FlushD = 0;
    RegWriteW = 0; RdW = 0; ResultW = 0;
    repeat (3) idle(1'b0);
    @(posedge clk); #1 rst = 1'b0;

    // Reset / idle state.
    idle(1'b0);
    @(negedge clk);
    chk("reset ValidD", ValidD, 0);
    chk("reset ReadyF", ReadyF, 1);
    chk("reset CountD", CountD, 0);
    chk("reset RegWriteD", RegWriteD, 0);

    // Give every register a known value; x1 starts at zero.
    for (int r = 1; r < 32; r++)
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'(r), (r == 1) ? 32'h0 : $urandom);
    idle(1'b0);

    // Single beat: addi x1,x0,5 at PC 0.
    pc_ctr = 0;
    drive(1'b1, 32'h0050_0093, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    idle(1'b0);
    @(negedge clk);
    chk("addi ValidD", ValidD, 1);
    chk("addi RegWriteD", RegWriteD, 1);
    chk("addi ALUSrcD", ALUSrcD, 1);
    chk("addi ExtImmD", ExtImmD, 5);
    chk("addi RdD", RdD, 1);
    idle(1'b0);

    // Fill under stall; 5th beat is refused, then push+pop keeps the queue full.
    for (int i = 0; i < 5; i++) drive(1'b1, rand_instr(), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("fill CountD", CountD, 4);
    chk("fill ReadyF", ReadyF, 0);
    drive(1'b1, rand_instr(), 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("full pushpop ReadyF", ReadyF, 1);
    idle(1'b1);
    @(negedge clk);
    chk("full pushpop CountD", CountD, 4);
    repeat (5) idle(1'b0);

    // Flush with 3 held entries and a same-cycle beat (stall also high).
    repeat (3) drive(1'b1, rand_instr(), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, rand_instr(), 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    idle(1'b0);
    @(negedge clk);
    chk("flush CountD", CountD, 0);
    chk("flush ValidD", ValidD, 0);

    // Bypass: head is add x2,x1,x1.
    drive(1'b1, 32'h0010_8133, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("bypass rd0 RD1D", RD1D, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("bypass RD1D", RD1D, 32'hDEAD_BEEF);
    chk("bypass RD2D", RD2D, 32'hDEAD_BEEF);

    // Illegal opcode (LUI) decodes as NOP and still pops.
    drive(1'b1, 32'h0000_0037, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    idle(1'b0);
    @(negedge clk);
    chk("lui ValidD", ValidD, 1);
    chk("lui IllegalD", IllegalD, 1);
    chk("lui RegWriteD", RegWriteD, 0);
    idle(1'b0);
    @(negedge clk);
    chk("lui popped CountD", CountD, 0);

    // Random traffic.
    for (int i = 0; i < 800; i++)
      drive($urandom_range(0, 99) < 70, rand_instr(), $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 4, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
            $urandom);
    repeat (8) idle(1'b0);
    @(negedge clk);
    chk("drain CountD", CountD, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
